sweep2ram: RTL and testbench

Parametrised successor to the single-format FIFO-to-frame-RAM writer in the ARINC 708 display path. Takes one radar sweep of range bins from the non-showahead bin FIFO and its scan angle from the ARINC word decoder. Maps the angle to a frame-buffer row, decimates bins into pixels (first-sample or max-hold), and writes them to the shared single-port frame RAM through a ready/valid write port. Optionally zero-fills the rest of the row.

---
 rtl/sweep2ram.sv | 209 ++++++++++++++++++++
 tb/tb_sweep2ram.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep2ram.sv
// sweep2ram: writes one radar sweep of FIFO range bins into a frame-RAM row,
// decimating bins to pixels (first-sample or max-hold) with optional zero-filled row tail.
`default_nettype none

module sweep2ram #(
    parameter int DATA_W  = 3,
    parameter int BINS    = 512,
    parameter int DECIM   = 1,
    parameter int WIDTH   = 640,
    parameter int HEIGHT  = 480,
    parameter int ANGLE_W = 12,
    parameter int ADDR_W  = $clog2(WIDTH*HEIGHT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sweep_start,
    input  logic [ANGLE_W-1:0] angle,
    input  logic [1:0]         mode,
    input  logic               err_clr,
    input  logic [DATA_W-1:0]  fifo_q,
    input  logic               fifo_empty,
    output logic               fifo_rdreq,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_wdata,
    output logic               ram_we,
    input  logic               ram_ready,
    output logic               busy,
    output logic               sweep_done,
    output logic               overrun
);

    localparam int PIX = BINS / DECIM;
    localparam int BW  = $clog2(BINS + 1);
    localparam int GW  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int HW  = $clog2(HEIGHT + 1);
    localparam int PW  = ANGLE_W + HW;

    generate
        if (PIX > WIDTH) begin : g_width_check
            $error("sweep2ram: BINS/DECIM exceeds WIDTH");
        end
        if (DECIM < 1 || DECIM > 8 || (DECIM & (DECIM - 1)) != 0) begin : g_decim_check
            $error("sweep2ram: DECIM must be a power of two in 1..8");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_READ  = 3'd2,
        S_CAPT  = 3'd3,
        S_WRITE = 3'd4,
        S_FILL  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t              state_q;
    logic [ANGLE_W-1:0]  angle_q;
    logic [1:0]          mode_q;
    logic [ADDR_W-1:0]   base_q;
    logic [BW-1:0]       bin_q;
    logic [GW-1:0]       grp_q;
    logic [CW-1:0]       col_q;
    logic [DATA_W-1:0]   acc_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [DATA_W-1:0]   ram_wdata_q;
    logic                ram_we_q;
    logic                busy_q;
    logic                done_q;
    logic                overrun_q;

    logic [PW-1:0]       row_prod_d;
    logic [ADDR_W-1:0]   row_d;
    logic [ADDR_W-1:0]   base_d;
    logic [DATA_W-1:0]   acc_d;
    logic [CW-1:0]       col_inc_d;
    logic                grp_last_d;
    logic                bins_left_d;

    // Full-precision product keeps row strictly below HEIGHT for every angle.
    assign row_prod_d  = PW'(angle_q) * PW'(HEIGHT);
    assign row_d       = ADDR_W'(row_prod_d >> ANGLE_W);
    assign base_d      = row_d * ADDR_W'(WIDTH);
    assign col_inc_d   = col_q + CW'(1);
    assign grp_last_d  = (grp_q == GW'(DECIM - 1));
    assign bins_left_d = (bin_q != BW'(BINS));

    always_comb begin
        acc_d = acc_q;
        if (grp_q == '0) begin
            acc_d = fifo_q;
        end else if (mode_q[0] && (fifo_q > acc_q)) begin
            acc_d = fifo_q;
        end
    end

    // Read request depends on the live empty flag so no read is ever issued while empty.
    assign fifo_rdreq = (state_q == S_READ) && !fifo_empty;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign ram_we     = ram_we_q;
    assign busy       = busy_q;
    assign sweep_done = done_q;
    assign overrun    = overrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            angle_q     <= '0;
            mode_q      <= '0;
            base_q      <= '0;
            bin_q       <= '0;
            grp_q       <= '0;
            col_q       <= '0;
            acc_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (sweep_start && busy_q) begin
                overrun_q <= 1'b1;
            end else if (err_clr) begin
                overrun_q <= 1'b0;
            end
            done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (sweep_start) begin
                        angle_q <= angle;
                        mode_q  <= mode;
                        busy_q  <= 1'b1;
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    base_q  <= base_d;
                    bin_q   <= '0;
                    grp_q   <= '0;
                    col_q   <= '0;
                    state_q <= S_READ;
                end
                S_READ: begin
                    if (!fifo_empty) begin
                        state_q <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    acc_q <= acc_d;
                    bin_q <= bin_q + 1'b1;
                    if (grp_last_d) begin
                        grp_q       <= '0;
                        ram_we_q    <= 1'b1;
                        ram_wdata_q <= acc_d;
                        ram_addr_q  <= base_q + ADDR_W'(col_q);
                        state_q     <= S_WRITE;
                    end else begin
                        grp_q   <= grp_q + 1'b1;
                        state_q <= S_READ;
                    end
                end
                S_WRITE: begin
                    if (ram_ready) begin
                        col_q <= col_inc_d;
                        if (bins_left_d) begin
                            ram_we_q <= 1'b0;
                            state_q  <= S_READ;
                        end else if (mode_q[1] && (col_inc_d < CW'(WIDTH))) begin
                            ram_wdata_q <= '0;
                            ram_addr_q  <= ram_addr_q + 1'b1;
                            state_q     <= S_FILL;
                        end else begin
                            ram_we_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_FILL: begin
                    if (ram_ready) begin
                        col_q <= col_inc_d;
                        if (col_inc_d == CW'(WIDTH)) begin
                            ram_we_q <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            ram_addr_q <= ram_addr_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sweep2ram.sv
// tb_sweep2ram: randomized scoreboard bench for sweep2ram (DECIM=4 build).
`default_nettype none

module tb_sweep2ram;

    localparam int DW      = 3;
    localparam int BINS    = 512;
    localparam int DECIM   = 4;
    localparam int WIDTH   = 640;
    localparam int HEIGHT  = 480;
    localparam int ANGLE_W = 12;
    localparam int AW      = 19;
    localparam int PIX     = BINS / DECIM;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sweep_start = 1'b0;
    logic [ANGLE_W-1:0] angle = '0;
    logic [1:0]         mode = '0;
    logic               err_clr = 1'b0;
    logic [DW-1:0]      fifo_q = '0;
    logic               fifo_empty = 1'b1;
    logic               fifo_rdreq;
    logic [AW-1:0]      ram_addr;
    logic [DW-1:0]      ram_wdata;
    logic               ram_we;
    logic               ram_ready = 1'b1;
    logic               busy;
    logic               sweep_done;
    logic               overrun;

    sweep2ram #(
        .DATA_W(DW), .BINS(BINS), .DECIM(DECIM), .WIDTH(WIDTH),
        .HEIGHT(HEIGHT), .ANGLE_W(ANGLE_W), .ADDR_W(AW)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .sweep_start(sweep_start), .angle(angle),
        .mode(mode), .err_clr(err_clr), .fifo_q(fifo_q), .fifo_empty(fifo_empty),
        .fifo_rdreq(fifo_rdreq), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_ready(ram_ready), .busy(busy),
        .sweep_done(sweep_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int done_cnt = 0;
    int done_base = 0;
    int done_cyc = 0;
    int t_start = 0;
    int stall_left = 0;
    bit rd_pending = 0;
    bit rnd_empty = 0;
    bit rnd_stall = 0;
    bit prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] fifo_src [$];
    wr_t           exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO and RAM environment: data appears the cycle after a read request.
    always @(posedge clk) begin
        #1;
        if (rd_pending) begin
            if (fifo_src.size() > 0) fifo_q = fifo_src.pop_front();
            rd_pending = 0;
        end
        fifo_empty = (fifo_src.size() == 0) || (rnd_empty && ($urandom_range(0, 2) == 0));
        if (stall_left > 0) begin
            ram_ready = 1'b0;
            stall_left--;
        end else if (rnd_stall && ($urandom_range(0, 15) == 0)) begin
            ram_ready = 1'b0;
            stall_left = 9;
        end else begin
            ram_ready = 1'b1;
        end
    end

    // Monitor: compares accepted writes with the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rdreq) begin
                check("rdreq_while_empty", {31'd0, fifo_empty}, 32'd0);
                rd_pending = 1;
                rd_cnt++;
            end
            if (prev_stall)
                check("stall_hold", {9'd0, ram_we, ram_addr, ram_wdata}, {9'd0, 1'b1, prev_addr, prev_data});
            if (ram_we && ram_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {13'd0, ram_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", {13'd0, ram_addr}, {13'd0, e.addr});
                    check("wr_data", {29'd0, ram_wdata}, {29'd0, e.data});
                end
                last_addr = ram_addr;
            end
            prev_stall = ram_we && !ram_ready;
            prev_addr  = ram_addr;
            prev_data  = ram_wdata;
            if (sweep_done) begin
                check("done_busy_low", {31'd0, busy}, 32'd0);
                check("done_writes_pending", exp_q.size(), 32'd0);
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            prev_stall = 0;
        end
    end

    // Reference model: row from angle, pixels from bin groups, optional zero tail.
    task automatic start_sweep(input logic [ANGLE_W-1:0] a, input logic [1:0] m, input int pat);
        logic [DW-1:0] b [BINS];
        int row;
        wr_t e;
        for (int i = 0; i < BINS; i++) begin
            b[i] = (pat == 0) ? DW'(i % 8) : DW'($urandom_range(0, 7));
            fifo_src.push_back(b[i]);
        end
        if (pat == 1) begin
            b[0] = 3'd1; b[1] = 3'd5; b[2] = 3'd2; b[3] = 3'd3;
            for (int i = 0; i < 4; i++) fifo_src[fifo_src.size() - BINS + i] = b[i];
        end
        row = (int'(a) * HEIGHT) / (1 << ANGLE_W);
        for (int p = 0; p < PIX; p++) begin
            logic [DW-1:0] mx;
            mx = b[p*DECIM];
            for (int g = 1; g < DECIM; g++) if (b[p*DECIM+g] > mx) mx = b[p*DECIM+g];
            e.addr = AW'(row * WIDTH + p);
            e.data = m[0] ? mx : b[p*DECIM];
            exp_q.push_back(e);
        end
        if (m[1]) begin
            for (int p = PIX; p < WIDTH; p++) begin
                e.addr = AW'(row * WIDTH + p);
                e.data = '0;
                exp_q.push_back(e);
            end
        end
        @(posedge clk); #1;
        sweep_start = 1'b1; angle = a; mode = m;
        t_start = cyc; rd_cnt = 0; done_base = done_cnt;
        @(posedge clk); #1;
        sweep_start = 1'b0;
        @(negedge clk);
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input int exp_cycles);
        int n;
        n = 0;
        while (done_cnt == done_base && n < 20000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == done_base) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("rd_count", rd_cnt, BINS);
            if (exp_cycles >= 0) check("sweep_cycles", done_cyc - t_start, exp_cycles);
            repeat (3) @(posedge clk);
            check("done_once", done_cnt - done_base, 32'd1);
        end
    endtask

    localparam int T_NOFILL = 2 + PIX * (2 * DECIM + 1);
    localparam int T_FILL   = T_NOFILL + (WIDTH - PIX);

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {9'd0, fifo_rdreq, ram_we, ram_addr, ram_wdata, busy, sweep_done, overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        start_sweep(12'h800, 2'b00, 0); wait_done(T_NOFILL);
        check("last_addr_row240", {13'd0, last_addr}, 32'd153600 + PIX - 1);
        start_sweep(12'h800, 2'b01, 1); wait_done(T_NOFILL);
        start_sweep(12'h800, 2'b00, 1); wait_done(T_NOFILL);
        start_sweep(12'hFFF, 2'b10, 2); wait_done(T_FILL);
        check("last_addr_row479", {13'd0, last_addr}, 32'd307199);
        start_sweep(12'h000, 2'b11, 0); wait_done(T_FILL);

        rnd_empty = 1; rnd_stall = 1;
        for (int k = 0; k < 3; k++) begin
            start_sweep(ANGLE_W'($urandom), 2'($urandom), 2);
            wait_done(-1);
        end

        // Overrun: extra start mid-sweep is dropped and flagged until cleared.
        start_sweep(ANGLE_W'($urandom), 2'b01, 2);
        n = 0;
        while (rd_cnt < 100 && n < 20000) begin @(posedge clk); n++; end
        #1; sweep_start = 1'b1; angle = ANGLE_W'($urandom);
        @(posedge clk); #1; sweep_start = 1'b0;
        @(negedge clk);
        check("overrun_set", {31'd0, overrun}, 32'd1);
        wait_done(-1);
        check("overrun_sticky", {31'd0, overrun}, 32'd1);
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        check("overrun_cleared", {31'd0, overrun}, 32'd0);

        // Asynchronous reset in the middle of the zero-fill tail at column 200.
        start_sweep(12'h400, 2'b10, 2);
        n = 0;
        while (!(ram_we && ram_addr == AW'(120 * WIDTH + 200)) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("reached_col200", {31'd0, ram_we}, 32'd1);
        #1; rst_n = 1'b0;
        #1;
        check("midsweep_reset_outputs", {9'd0, fifo_rdreq, ram_we, ram_addr, ram_wdata, busy, sweep_done, overrun}, 32'd0);
        exp_q.delete();
        fifo_src.delete();
        rd_pending = 0;
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        start_sweep(12'hA55, 2'b11, 2); wait_done(-1);
        rnd_empty = 0; rnd_stall = 0;
        start_sweep(12'h123, 2'b00, 2); wait_done(-1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
